ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: RAM word address width.
REQ-003 SHALL have parameter BYTE_WIDTH, default 8: bits per byte lane.
REQ-004 SHALL have parameter BATCH_WIDTH, default 4: byte lanes per word; DW = BYTE_WIDTH*BATCH_WIDTH.
REQ-005 SHALL have port clk_i, input, 1: the single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n_i, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid_i, input, NUM_REQ: per-requester request valid.
REQ-008 SHALL have port req_ready_o, output, NUM_REQ: per-requester request accepted this cycle.
REQ-009 SHALL have port req_addr_i, input, NUM_REQ*ADDR_WIDTH: packed addresses, requester k at slice k.
REQ-010 SHALL have port req_wdata_i, input, NUM_REQ*DW: packed write data.
REQ-011 SHALL have port req_byte_en_i, input, NUM_REQ*BATCH_WIDTH: packed byte enables; nonzero = write, zero = read.
REQ-012 SHALL have port rsp_valid_o, output, NUM_REQ: one-hot response strobe.
REQ-013 SHALL have port rsp_rdata_o, output, DW: read data, shared by all requesters.
REQ-014 SHALL have ports addr_o (ADDR_WIDTH), write_o (DW), byte_en_o (BATCH_WIDTH), outputs: RAM port drive.
REQ-015 SHALL have port data_i, input, DW: RAM read data, valid one cycle after addr_o.

Function
REQ-016 SHALL grant at most one requester per cycle; req_ready_o is one-hot or zero, and high only where req_valid_i is high.
REQ-017 SHALL arbitrate round-robin: a pointer names the highest-priority requester, and the search runs upward from it modulo NUM_REQ.
REQ-018 SHALL, after a grant to requester k, set the pointer to (k+1) mod NUM_REQ; with no grant, the pointer holds.
REQ-019 SHALL drive addr_o, write_o and byte_en_o combinationally from the granted slice, with byte_en_o = 0 and addr_o held when there is no grant, so that no spurious write occurs.
REQ-020 SHALL assert rsp_valid_o[k] exactly one cycle after a grant to k, for both reads and writes.
REQ-021 SHALL drive rsp_rdata_o = data_i; the value is meaningful only for a read response.
REQ-022 SHALL sustain back-to-back grants, one per cycle, to the same or different requesters with no bubble.
REQ-023 SHALL NOT grant anyone when no requester is valid; the pointer is unchanged.
REQ-024 SHALL treat requester NUM_REQ-1 correctly at pointer wrap: a grant to it sets the pointer to 0.
REQ-025 SHALL keep combinational request to ready paths free of loops; req_ready_o does not depend on rsp_*.

Reset
REQ-026 SHALL, while rst_n_i is low, force pointer = 0, rsp_valid_o = 0, req_ready_o = 0 and byte_en_o = 0.
REQ-027 SHALL drop any response pending at reset assertion; no rsp_valid_o is issued for it after release.
REQ-028 SHALL permit a grant in the first clock edge after rst_n_i deasserts.

Configuration
REQ-029 SHALL support macro ARB_BURST_LOCK_EN; when defined, the module adds input req_last_i (NUM_REQ).
REQ-030 SHALL, with ARB_BURST_LOCK_EN defined, hold the grant on the locked requester until a beat with req_last_i = 1 is accepted, with other requesters stalled; the lock persists across cycles where the holder's valid is low.
REQ-031 SHALL, with ARB_BURST_LOCK_EN defined, update the pointer only when a last beat is accepted; reset clears the lock.
REQ-032 SHALL, without ARB_BURST_LOCK_EN, have no req_last_i port and arbitrate every beat independently.

Verification
REQ-033 SHALL verify: both requesters issue continuous reads from reset -> grants alternate 0,1,0,1, and each rsp_valid arrives one cycle after its grant.
REQ-034 SHALL verify: req0 writes 0xDEADBEEF, byte_en 0xF, addr 0x10; then req1 reads 0x10 -> rsp_rdata_o = 0xDEADBEEF in rsp_valid_o[1] cycle.
REQ-035 SHALL verify: req0 writes byte_en 0x3 of 0x1234 over 0xFFFFFFFF at addr 0x20, then reads it -> read returns 0xFFFF1234.
REQ-036 SHALL verify: NUM_REQ = 3, only req2 valid for one cycle -> req2 granted and pointer = 0; idle cycles then hold the pointer.
REQ-037 SHALL verify: rst_n_i pulsed low in the cycle after a grant -> no rsp_valid_o, and pointer = 0 after release.
REQ-038 SHALL verify, with ARB_BURST_LOCK_EN: req0 issues a 4-beat burst, last on beat 4, while req1 is valid -> req1 is granted only in cycle 5.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter sharing one single-port RAM among NUM_REQ requesters
// Ports: clk_i / rst_n_i             clock, asynchronous active-low reset
//        req_valid_i / req_ready_o   per-requester handshake, ready is one-hot or zero
//        req_addr_i / req_wdata_i / req_byte_en_i  packed request slices (byte_en == 0 means read)
//        rsp_valid_o / rsp_rdata_o   one-hot response strobe one cycle after grant, shared read data
//        addr_o / write_o / byte_en_o / data_i     RAM port drive and RAM read data
// Option: define ARB_BURST_LOCK_EN to add req_last_i and hold the grant for a whole burst.
module ram_port_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_WIDTH  = 16,
    parameter int BYTE_WIDTH  = 8,
    parameter int BATCH_WIDTH = 4
) (
    input  logic                                        clk_i,
    input  logic                                        rst_n_i,
    input  logic [NUM_REQ-1:0]                          req_valid_i,
    output logic [NUM_REQ-1:0]                          req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]               req_addr_i,
    input  logic [NUM_REQ*BYTE_WIDTH*BATCH_WIDTH-1:0]   req_wdata_i,
    input  logic [NUM_REQ*BATCH_WIDTH-1:0]              req_byte_en_i,
`ifdef ARB_BURST_LOCK_EN
    input  logic [NUM_REQ-1:0]                          req_last_i,
`endif
    output logic [NUM_REQ-1:0]                          rsp_valid_o,
    output logic [BYTE_WIDTH*BATCH_WIDTH-1:0]           rsp_rdata_o,
    output logic [ADDR_WIDTH-1:0]                       addr_o,
    output logic [BYTE_WIDTH*BATCH_WIDTH-1:0]           write_o,
    output logic [BATCH_WIDTH-1:0]                      byte_en_o,
    input  logic [BYTE_WIDTH*BATCH_WIDTH-1:0]           data_i
);
    localparam int DW = BYTE_WIDTH * BATCH_WIDTH;
    localparam int PW = $clog2(NUM_REQ);
    logic [PW-1:0]         r_ptr;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [PW:0]           w_k;
    logic [PW-1:0]         w_srch, w_idx, w_next;
    logic                  w_any, w_gnt, w_last;
`ifdef ARB_BURST_LOCK_EN
    logic                  r_lock;
    logic [PW-1:0]         r_lock_idx;
`endif
    always_comb begin
        w_srch = '0;
        w_any  = 1'b0;
        w_k    = '0;
        // walk from lowest to highest priority so the highest-priority valid requester wins
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_k = {1'b0, r_ptr} + (PW+1)'(i);
            if (w_k >= (PW+1)'(NUM_REQ)) w_k = w_k - (PW+1)'(NUM_REQ);
            if (req_valid_i[w_k[PW-1:0]]) begin
                w_any  = 1'b1;
                w_srch = w_k[PW-1:0];
            end
        end
`ifdef ARB_BURST_LOCK_EN
        // a locked holder keeps the port even while its valid is low
        w_idx  = r_lock ? r_lock_idx : w_srch;
        w_gnt  = rst_n_i && (r_lock ? req_valid_i[r_lock_idx] : w_any);
        w_last = req_last_i[w_idx];
`else
        w_idx  = w_srch;
        w_gnt  = rst_n_i && w_any;
        w_last = 1'b1;
`endif
        w_next      = w_idx == PW'(NUM_REQ - 1) ? '0 : w_idx + 1'b1;
        req_ready_o = w_gnt ? NUM_REQ'(1) << w_idx : '0;
        // address is held when idle and byte enables drop, so the RAM sees a harmless read
        addr_o      = w_gnt ? req_addr_i[w_idx*ADDR_WIDTH +: ADDR_WIDTH] : r_addr;
        write_o     = req_wdata_i[w_idx*DW +: DW];
        byte_en_o   = w_gnt ? req_byte_en_i[w_idx*BATCH_WIDTH +: BATCH_WIDTH] : '0;
        rsp_valid_o = r_rsp_valid;
        rsp_rdata_o = data_i;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ptr       <= '0;
            r_rsp_valid <= '0;
            r_addr      <= '0;
`ifdef ARB_BURST_LOCK_EN
            r_lock      <= 1'b0;
            r_lock_idx  <= '0;
`endif
        end else begin
            r_rsp_valid <= req_ready_o;
            r_addr      <= addr_o;
            if (w_gnt && w_last) r_ptr <= w_next;
`ifdef ARB_BURST_LOCK_EN
            if (w_gnt) begin
                r_lock     <= !w_last;
                r_lock_idx <= w_idx;
            end
`endif
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scoreboard bench for ram_port_arbiter with a behavioural RAM and reference model
module tb_ram_port_arbiter;
    localparam int N  = 3;
    localparam int AW = 16;
    localparam int BW = 4;
    localparam int DW = 32;
    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;
    logic [N-1:0]    req_valid_i, req_ready_o, rsp_valid_o;
    logic [N*AW-1:0] req_addr_i;
    logic [N*DW-1:0] req_wdata_i;
    logic [N*BW-1:0] req_byte_en_i;
    logic [DW-1:0]   rsp_rdata_o, write_o, data_i;
    logic [AW-1:0]   addr_o;
    logic [BW-1:0]   byte_en_o;
`ifdef ARB_BURST_LOCK_EN
    logic [N-1:0]    req_last_i;
`endif
    ram_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .BATCH_WIDTH(BW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_byte_en_i(req_byte_en_i),
`ifdef ARB_BURST_LOCK_EN
        .req_last_i(req_last_i),
`endif
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .addr_o(addr_o), .write_o(write_o), .byte_en_o(byte_en_o), .data_i(data_i)
    );
    always #5 clk_i = ~clk_i;
    bit [DW-1:0] ram [1<<AW];
    bit [DW-1:0] ref_mem [1<<AW];
    always @(posedge clk_i) begin
        data_i <= ram[addr_o];
        for (int b = 0; b < BW; b++)
            if (byte_en_o[b]) ram[addr_o][b*8 +: 8] <= write_o[b*8 +: 8];
    end
    typedef struct { int due; int idx; bit rd; logic [DW-1:0] data; } rsp_t;
    rsp_t q[$];
    int cyc = 0, n_chk = 0, n_err = 0;
    int mptr = 0, mlock = 0, midx = 0;
    logic [AW-1:0] mlast = '0;
    logic [AW-1:0] a [N];
    logic [DW-1:0] wd [N];
    logic [BW-1:0] be [N];
    logic [N-1:0]  lst;
    int got;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask
    always @(posedge clk_i) cyc++;
    // monitor: every cycle the strobe must match what the scoreboard says is due now
    always @(negedge clk_i) begin
        logic [N-1:0] ev;
        rsp_t e;
        ev = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e  = q.pop_front();
            ev = N'(1) << e.idx;
            if (e.rd) chk("rdata", rsp_rdata_o, e.data);
        end
        chk("rsp_valid", rsp_valid_o, ev);
    end
    // one cycle: drive, predict the grant from round-robin rules, score, advance
    task automatic step(input logic [N-1:0] v, output int rdy);
        int g, lb;
        req_valid_i = v;
        for (int k = 0; k < N; k++) begin
            req_addr_i[k*AW +: AW]    = a[k];
            req_wdata_i[k*DW +: DW]   = wd[k];
            req_byte_en_i[k*BW +: BW] = be[k];
        end
`ifdef ARB_BURST_LOCK_EN
        req_last_i = lst;
`endif
        #3;
        rdy = int'(req_ready_o);
        chk("ptr", dut.r_ptr, mptr);
        g = -1;
        if (mlock != 0) begin
            if (v[midx]) g = midx;
        end else
            for (int i = 0; i < N; i++)
                if (g < 0 && v[(mptr + i) % N]) g = (mptr + i) % N;
        chk("ready", req_ready_o, g >= 0 ? 1 << g : 0);
        if (g >= 0) begin
            chk("addr", addr_o, a[g]);
            chk("byte_en", byte_en_o, be[g]);
            if (be[g] != 0) chk("wdata", write_o, wd[g]);
            q.push_back('{cyc + 1, g, be[g] == 0, ref_mem[a[g]]});
            for (int b = 0; b < BW; b++)
                if (be[g][b]) ref_mem[a[g]][b*8 +: 8] = wd[g][b*8 +: 8];
            mlast = a[g];
`ifdef ARB_BURST_LOCK_EN
            lb = int'(lst[g]);
`else
            lb = 1;
`endif
            if (lb != 0) begin
                mptr  = (g + 1) % N;
                mlock = 0;
            end else begin
                mlock = 1;
                midx  = g;
            end
        end else begin
            chk("idle_byte_en", byte_en_o, 0);
            chk("idle_addr", addr_o, mlast);
        end
        @(posedge clk_i);
        #1;
    endtask
    task automatic do_reset();
        rst_n_i = 1'b0;
        q.delete();
        mptr = 0; mlock = 0; mlast = '0;
        req_valid_i   = '1;
        req_byte_en_i = '1;
        #3;
        chk("rst_ready", req_ready_o, 0);
        chk("rst_byte_en", byte_en_o, 0);
        chk("rst_ptr", dut.r_ptr, 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i     = 1'b1;
        req_valid_i = '0;
    endtask
    task automatic rnd_slots();
        for (int k = 0; k < N; k++) begin
            a[k]  = AW'($urandom_range(0, 15));
            wd[k] = $urandom;
            be[k] = $urandom_range(0, 3) == 0 ? '0 : BW'($urandom);
        end
        lst = N'($urandom);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        req_valid_i = '0; req_addr_i = '0; req_wdata_i = '0; req_byte_en_i = '0; lst = '0;
        for (int k = 0; k < N; k++) begin a[k] = AW'(k); wd[k] = '0; be[k] = '0; end
        @(posedge clk_i);
        #1;
        do_reset();
        // continuous reads from req0 and req1 straight out of reset alternate 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            step(3'b011, got);
            chk("alternate", got, i % 2 == 0 ? 1 : 2);
        end
        a[0] = 16'h10; wd[0] = 32'hDEADBEEF; be[0] = 4'hF;
        step(3'b001, got);
        a[1] = 16'h10; be[1] = '0;
        step(3'b010, got);
        a[0] = 16'h20; wd[0] = 32'hFFFFFFFF; be[0] = 4'hF;
        step(3'b001, got);
        wd[0] = 32'h00001234; be[0] = 4'h3;
        step(3'b001, got);
        be[0] = '0;
        step(3'b001, got);
        // lone grant to the top requester wraps the pointer; idle cycles hold it
        step(3'b100, got);
        chk("req2_grant", got, 4);
        chk("wrap_ptr", dut.r_ptr, 0);
        repeat (3) step(3'b000, got);
        // reset in the cycle after a grant drops that response
        a[1] = 16'h5; be[1] = '0;
        step(3'b010, got);
        do_reset();
        step(3'b000, got);
        chk("ptr_after_rst", dut.r_ptr, 0);
`ifdef ARB_BURST_LOCK_EN
        for (int k = 0; k < N; k++) be[k] = '0;
        for (int i = 0; i < 5; i++) begin
            lst = i == 3 ? 3'b011 : 3'b010;
            step(3'b011, got);
            chk("burst_grant", got, i < 4 ? 1 : 2);
        end
`endif
        repeat (400) begin
            rnd_slots();
            step(N'($urandom), got);
        end
        for (int k = 0; k < N; k++) be[k] = '0;
        lst = '1;
        repeat (3) step(3'b000, got);
        chk("drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
